fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks the instruction ROM, folds EXT prefix words
// into an extension payload, and hands one packet at a time to the core.
module fetch_unit #(
   parameter int             IW       = 9,
   parameter int             PW       = 8,
   parameter logic [3:0]     EXT_OPC  = 4'b1110,
   parameter int             MAX_EXT  = 2,
   parameter logic [PW-1:0]  RESET_PC = '0,
   localparam int            EW       = IW - 1,
   localparam int            XW       = EW * MAX_EXT,
   localparam int            CW       = $clog2(MAX_EXT + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic [PW-1:0] imem_addr,
   input  logic [IW-1:0] imem_data,
   input  logic          redirect_valid,
   input  logic [PW-1:0] redirect_target,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [IW-1:0] instr_out,
   output logic [PW-1:0] instr_pc,
   output logic [XW-1:0] ext_data,
   output logic [CW-1:0] ext_count,
   output logic          ext_err
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_pc;
   logic [XW-1:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic          r_instrValid;
   logic [IW-1:0] r_instrOut;
   logic [PW-1:0] r_instrPc;
   logic [XW-1:0] r_extData;
   logic [CW-1:0] r_extCount;
   logic          r_extErr;

   logic          w_isPrefix;
   logic [XW-1:0] w_accNext;
   logic          w_cntFull;
   logic [PW-1:0] w_pcInc;

   // The shift naturally discards the oldest payload once the accumulator is full.
   assign w_isPrefix = (imem_data[IW-1:IW-4] == EXT_OPC);
   assign w_accNext  = (r_acc << EW) | XW'(imem_data[EW-1:0]);
   assign w_cntFull  = (r_cnt == CW'(MAX_EXT));
   assign w_pcInc    = r_pc + PW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_instrValid <= 1'b0;
         r_instrOut   <= '0;
         r_instrPc    <= '0;
         r_extData    <= '0;
         r_extCount   <= '0;
         r_extErr     <= 1'b0;
      end else if (start) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_instrValid <= 1'b0;
         r_extErr     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= FETCH;
            end
            FETCH: begin
               if (redirect_valid) begin
                  r_pc         <= redirect_target;
                  r_acc        <= '0;
                  r_cnt        <= '0;
                  r_instrValid <= 1'b0;
                  r_state      <= FETCH;
               end else if (w_isPrefix) begin
                  r_acc <= w_accNext;
                  r_pc  <= w_pcInc;
                  if (w_cntFull) begin
                     r_extErr <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end else begin
                  r_instrOut   <= imem_data;
                  r_instrPc    <= r_pc;
                  r_extData    <= r_acc;
                  r_extCount   <= r_cnt;
                  r_instrValid <= 1'b1;
                  r_acc        <= '0;
                  r_cnt        <= '0;
                  r_pc         <= w_pcInc;
                  r_state      <= HOLD;
               end
            end
            HOLD: begin
               // A redirect drops the held packet whether or not it was taken.
               if (redirect_valid) begin
                  r_pc         <= redirect_target;
                  r_acc        <= '0;
                  r_cnt        <= '0;
                  r_instrValid <= 1'b0;
                  r_state      <= FETCH;
               end else if (instr_ready) begin
                  r_instrValid <= 1'b0;
                  r_state      <= FETCH;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign imem_addr   = r_pc;
   assign instr_valid = r_instrValid;
   assign instr_out   = r_instrOut;
   assign instr_pc    = r_instrPc;
   assign ext_data    = r_extData;
   assign ext_count   = r_extCount;
   assign ext_err     = r_extErr;

endmodule
